// File: rtl/ext_bus_pkg.sv
// Shared types and helpers for the external parallel bus bridge.
// The phase encoding is common to the bridge and anything probing its state.
package ext_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } ext_bus_state_t;

  // Largest of three cycle counts; sizes the shared phase counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous GPIO inputs; clears to 0 in reset.
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] meta_d;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] sync_d;

  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/ext_bus_bridge.sv
// Turns one accepted CPU access into a timed setup/strobe/hold cycle on an
// external asynchronous parallel bus, with wait-stretch and strobe timeout.
module ext_bus_bridge
  import ext_bus_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int SETUP_CYCLES   = 1,
  parameter int STROBE_CYCLES  = 2,
  parameter int HOLD_CYCLES    = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic [ADDR_WIDTH-1:0] address_i,
  input  logic                  address_valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  data_valid_i,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  data_valid_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [ADDR_WIDTH-1:0] bus_addr_o,
  output logic [DATA_WIDTH-1:0] bus_data_o,
  output logic                  bus_data_oe_o,
  input  logic [DATA_WIDTH-1:0] bus_data_i,
  output logic                  bus_rd_n_o,
  output logic                  bus_wr_n_o,
  input  logic                  bus_wait_i
);

  localparam int CNT_W = $clog2(max3(SETUP_CYCLES, HOLD_CYCLES, TIMEOUT_CYCLES) + 1);

  localparam logic [CNT_W-1:0] SETUP_N   = CNT_W'(SETUP_CYCLES);
  localparam logic [CNT_W-1:0] STROBE_N  = CNT_W'(STROBE_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_N    = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] TIMEOUT_N = CNT_W'(TIMEOUT_CYCLES);

  if (STROBE_CYCLES < 1) begin : g_bad_strobe
    $error("ext_bus_bridge: STROBE_CYCLES must be at least 1");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("ext_bus_bridge: HOLD_CYCLES must be at least 1");
  end
  if (TIMEOUT_CYCLES < STROBE_CYCLES) begin : g_bad_timeout
    $error("ext_bus_bridge: TIMEOUT_CYCLES must be at least STROBE_CYCLES");
  end

  ext_bus_state_t state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] bdata_q, bdata_d;
  logic                  oe_q, oe_d;
  logic                  rd_n_q, rd_n_d;
  logic                  wr_n_q, wr_n_d;
  logic                  ready_q, ready_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  dvalid_q, dvalid_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  wait_sync;
  logic                  strobe_min;
  logic                  strobe_max;

  sync2 #(.WIDTH(1)) u_wait_sync (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .d_i     (bus_wait_i),
    .q_o     (wait_sync)
  );

  // cnt_q holds the 1-based index of the current cycle within a phase.
  always_comb begin
    cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    strobe_min = (cnt_q >= STROBE_N);
    strobe_max = (cnt_q >= TIMEOUT_N);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_inc;
    wr_d     = wr_q;
    addr_d   = addr_q;
    bdata_d  = bdata_q;
    data_d   = data_q;
    done_d   = 1'b0;
    dvalid_d = 1'b0;
    error_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (address_valid_i) begin
          addr_d  = address_i;
          wr_d    = data_valid_i;
          if (data_valid_i) bdata_d = data_i;
          cnt_d   = CNT_W'(1);
          state_d = (SETUP_CYCLES == 0) ? STROBE : SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_N) begin
          cnt_d   = CNT_W'(1);
          state_d = STROBE;
        end
      end
      STROBE: begin
        // Leaving with the wait still asserted can only be the forced exit.
        if ((strobe_min && !wait_sync) || strobe_max) begin
          cnt_d    = CNT_W'(1);
          state_d  = HOLD;
          done_d   = 1'b1;
          dvalid_d = !wr_q;
          error_d  = wait_sync;
          if (!wr_q) data_d = wait_sync ? '1 : bus_data_i;
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_N) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Pin-level outputs are registered from the next phase so they switch cleanly.
    ready_d = (state_d == IDLE);
    rd_n_d  = !((state_d == STROBE) && !wr_d);
    wr_n_d  = !((state_d == STROBE) && wr_d);
    oe_d    = (state_d != IDLE) && wr_d;
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      bdata_q  <= '0;
      oe_q     <= 1'b0;
      rd_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      ready_q  <= 1'b1;
      data_q   <= '0;
      dvalid_q <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      bdata_q  <= bdata_d;
      oe_q     <= oe_d;
      rd_n_q   <= rd_n_d;
      wr_n_q   <= wr_n_d;
      ready_q  <= ready_d;
      data_q   <= data_d;
      dvalid_q <= dvalid_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

  assign ready_o       = ready_q;
  assign data_o        = data_q;
  assign data_valid_o  = dvalid_q;
  assign done_o        = done_q;
  assign error_o       = error_q;
  assign bus_addr_o    = addr_q;
  assign bus_data_o    = bdata_q;
  assign bus_data_oe_o = oe_q;
  assign bus_rd_n_o    = rd_n_q;
  assign bus_wr_n_o    = wr_n_q;

endmodule

// File: tb/tb_ext_bus_bridge.sv
// Directed bench for ext_bus_bridge: three parameterisations sharing clock and reset,
// per-cycle pin checks and a completion scoreboard of {error, data_valid, data}.
module tb_ext_bus_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] address_i = '0;
  logic [7:0]  data_i = '0;
  logic [7:0]  bus_data_i = '0;

  logic        av [3];
  logic        dv [3];
  logic        bw [3];
  logic        rdy [3];
  logic        dvo [3];
  logic        done [3];
  logic        err [3];
  logic        rdn [3];
  logic        wrn [3];
  logic        oe [3];
  logic [7:0]  dout [3];
  logic [7:0]  bdo [3];
  logic [15:0] baddr [3];

  int          total = 0;
  int          bad = 0;
  int          sel = 0;
  logic [7:0]  model_d [3];
  logic [9:0]  exp_q [$];
  logic [15:0] nxt_a;
  logic [7:0]  nxt_wd;
  logic        nxt_wr;

  always #5 clk = ~clk;

  ext_bus_bridge u_def (
    .clock_i(clk), .reset_i(rst_n), .address_i(address_i), .address_valid_i(av[0]),
    .data_i(data_i), .data_valid_i(dv[0]), .ready_o(rdy[0]), .data_o(dout[0]),
    .data_valid_o(dvo[0]), .done_o(done[0]), .error_o(err[0]), .bus_addr_o(baddr[0]),
    .bus_data_o(bdo[0]), .bus_data_oe_o(oe[0]), .bus_data_i(bus_data_i),
    .bus_rd_n_o(rdn[0]), .bus_wr_n_o(wrn[0]), .bus_wait_i(bw[0])
  );

  ext_bus_bridge #(.TIMEOUT_CYCLES(8)) u_to (
    .clock_i(clk), .reset_i(rst_n), .address_i(address_i), .address_valid_i(av[1]),
    .data_i(data_i), .data_valid_i(dv[1]), .ready_o(rdy[1]), .data_o(dout[1]),
    .data_valid_o(dvo[1]), .done_o(done[1]), .error_o(err[1]), .bus_addr_o(baddr[1]),
    .bus_data_o(bdo[1]), .bus_data_oe_o(oe[1]), .bus_data_i(bus_data_i),
    .bus_rd_n_o(rdn[1]), .bus_wr_n_o(wrn[1]), .bus_wait_i(bw[1])
  );

  ext_bus_bridge #(.SETUP_CYCLES(0), .HOLD_CYCLES(3)) u_s0 (
    .clock_i(clk), .reset_i(rst_n), .address_i(address_i), .address_valid_i(av[2]),
    .data_i(data_i), .data_valid_i(dv[2]), .ready_o(rdy[2]), .data_o(dout[2]),
    .data_valid_o(dvo[2]), .done_o(done[2]), .error_o(err[2]), .bus_addr_o(baddr[2]),
    .bus_data_o(bdo[2]), .bus_data_oe_o(oe[2]), .bus_data_i(bus_data_i),
    .bus_rd_n_o(rdn[2]), .bus_wr_n_o(wrn[2]), .bus_wait_i(bw[2])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Runs one access on instance sel. Returns in the cycle where ready_o is back high.
  // s/t/h: expected setup, actual strobe and hold lengths; wait is driven high in
  // cycles w_from..w_to; keep holds address_valid with the nxt_* request during busy.
  task automatic access(input logic [15:0] a, input logic wr, input logic [7:0] wd,
                        input logic [7:0] rd, input int s, input int t, input int h,
                        input int w_from, input int w_to, input logic exp_err,
                        input logic keep);
    int         guard;
    int         last;
    logic       strobe_on;
    logic [9:0] item;
    guard = 0;
    while (!rdy[sel] && guard < 20) begin
      tick();
      guard++;
    end
    check($sformatf("ready_before_%0h", a), rdy[sel], 1'b1);
    address_i  = a;
    data_i     = wd;
    dv[sel]    = wr;
    av[sel]    = 1'b1;
    bus_data_i = rd;
    if (!wr) model_d[sel] = exp_err ? 8'hFF : rd;
    exp_q.push_back({exp_err, !wr, model_d[sel]});
    tick();
    if (keep) begin
      address_i = nxt_a;
      data_i    = nxt_wd;
      dv[sel]   = nxt_wr;
    end else begin
      av[sel]   = 1'b0;
      address_i = ~a;
      data_i    = ~wd;
    end
    last = s + t + h + 1;
    for (int c = 1; c <= last; c++) begin
      bw[sel]   = (c >= w_from) && (c <= w_to);
      strobe_on = (c >= s + 1) && (c <= s + t);
      check($sformatf("ready_c%0d", c), rdy[sel], c == last);
      check($sformatf("rd_n_c%0d", c), rdn[sel], !(strobe_on && !wr));
      check($sformatf("wr_n_c%0d", c), wrn[sel], !(strobe_on && wr));
      check($sformatf("done_c%0d", c), done[sel], c == s + t + 1);
      if (c < last) begin
        check($sformatf("oe_c%0d", c), oe[sel], wr);
        check($sformatf("addr_c%0d", c), baddr[sel], a);
        if (wr) check($sformatf("bus_data_c%0d", c), bdo[sel], wd);
      end else begin
        check($sformatf("oe_idle_c%0d", c), oe[sel], 1'b0);
      end
      if (c != s + t + 1) check($sformatf("err_dv_quiet_c%0d", c), {err[sel], dvo[sel]}, 2'b00);
      if (done[sel]) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", 1'b1, 1'b0);
        end else begin
          item = exp_q.pop_front();
          check($sformatf("sb_result_%0h", a), {err[sel], dvo[sel], dout[sel]}, item);
        end
      end
      if (c < last) tick();
    end
    bw[sel] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      av[i] = 1'b0;
      dv[i] = 1'b0;
      bw[i] = 1'b0;
      model_d[i] = 8'h00;
    end
    nxt_a  = '0;
    nxt_wd = '0;
    nxt_wr = 1'b0;

    // Reset values on every instance
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_ready_%0d", i), rdy[i], 1'b1);
      check($sformatf("rst_strobes_%0d", i), {rdn[i], wrn[i]}, 2'b11);
      check($sformatf("rst_oe_%0d", i), oe[i], 1'b0);
      check($sformatf("rst_buses_%0d", i), {baddr[i], bdo[i], dout[i]}, 32'h0);
      check($sformatf("rst_pulses_%0d", i), {done[i], dvo[i], err[i]}, 3'b000);
    end
    rst_n = 1'b1;
    tick();

    // Default timing: read, write, then a wait-stretched read
    sel = 0;
    access(16'h8000, 1'b0, 8'h00, 8'h5A, 1, 2, 1, 99, 0, 1'b0, 1'b0);
    check("read_data_hold", dout[0], 8'h5A);
    access(16'h2007, 1'b1, 8'h3C, 8'h00, 1, 2, 1, 99, 0, 1'b0, 1'b0);
    check("data_o_kept_over_write", dout[0], 8'h5A);
    // Wait high in cycles 1..6 is seen synchronised in cycles 3..8, so strobe spans 2..9.
    access(16'h0042, 1'b0, 8'h00, 8'hA7, 1, 8, 1, 1, 6, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      access(16'($urandom_range(0, 16'hFFFF)), 1'($urandom_range(0, 1)),
             8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             1, 2, 1, 99, 0, 1'b0, 1'b0);
    end

    // Timeout at 8 strobe cycles with wait stuck high, then a clean read
    sel = 1;
    access(16'h0100, 1'b0, 8'h00, 8'h11, 1, 8, 1, 1, 1000, 1'b1, 1'b0);
    access(16'h0101, 1'b0, 8'h00, 8'h77, 1, 2, 1, 99, 0, 1'b0, 1'b0);

    // No setup, long hold; the second request is held during busy
    sel    = 2;
    nxt_a  = 16'hF0F0;
    nxt_wd = 8'h00;
    nxt_wr = 1'b0;
    access(16'h0F0F, 1'b1, 8'h99, 8'hC3, 0, 2, 3, 99, 0, 1'b0, 1'b1);
    access(16'hF0F0, 1'b0, 8'h00, 8'hC3, 0, 2, 3, 99, 0, 1'b0, 1'b0);

    // Reset during STROBE aborts without done
    sel        = 0;
    address_i  = 16'h1234;
    dv[0]      = 1'b0;
    av[0]      = 1'b1;
    bus_data_i = 8'hEE;
    tick();
    av[0] = 1'b0;
    tick();
    check("pre_reset_strobe", rdn[0], 1'b0);
    rst_n = 1'b0;
    tick();
    check("abort_ready", rdy[0], 1'b1);
    check("abort_strobes", {rdn[0], wrn[0]}, 2'b11);
    check("abort_oe", oe[0], 1'b0);
    check("abort_buses", {baddr[0], dout[0]}, 24'h0);
    check("abort_no_done", {done[0], dvo[0], err[0]}, 3'b000);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) model_d[i] = 8'h00;
    tick();
    check("after_reset_no_done", done[0], 1'b0);
    access(16'h4321, 1'b0, 8'h00, 8'h3E, 1, 2, 1, 99, 0, 1'b0, 1'b0);

    check("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ext_bus_bridge.md
# ext_bus_bridge

Parametrised bridge between the CPU's native bus (address/data with valid flags) and an external asynchronous parallel bus on board GPIO pins, replacing direct wiring of CPU signals to pins. It converts one accepted CPU access into a timed read or write cycle with programmable setup, strobe and hold phases. The external device can stretch the strobe phase with a wait input, bounded by a timeout. Instantiated in board toplevels between `cpu` and the GPIO header, in the CPU clock domain.

## Interface
- `ADDR_WIDTH`, 16: CPU/external address width.
- `DATA_WIDTH`, 8: data width.
- `SETUP_CYCLES`, 1: cycles address/data are driven before the strobe; 0 skips SETUP.
- `STROBE_CYCLES`, 2: minimum strobe-low cycles; must be ≥ 1.
- `HOLD_CYCLES`, 1: cycles address/data are held after the strobe; must be ≥ 1.
- `TIMEOUT_CYCLES`, 255: maximum strobe-low cycles; must be ≥ `STROBE_CYCLES`.
- `clock_i` in 1: system clock.
- `reset_i` in 1: reset, synchronous, active-low (0 = reset).
- `address_i` in ADDR_WIDTH: CPU address.
- `address_valid_i` in 1: CPU requests an access.
- `data_i` in DATA_WIDTH: CPU write data.
- `data_valid_i` in 1: when high at acceptance, the access is a write; otherwise a read.
- `ready_o` out 1: bridge idle and able to accept a request.
- `data_o` out DATA_WIDTH: read data; holds its value between reads.
- `data_valid_o` out 1: one-cycle pulse when a read completes.
- `done_o` out 1: one-cycle pulse when any access completes.
- `error_o` out 1: one-cycle pulse, coincident with `done_o`, on timeout.
- `bus_addr_o` out ADDR_WIDTH: external address.
- `bus_data_o` out DATA_WIDTH: external write data.
- `bus_data_oe_o` out 1: data pin output enable (write cycles only).
- `bus_data_i` in DATA_WIDTH: external read data.
- `bus_rd_n_o`, `bus_wr_n_o` out 1: active-low read and write strobes.
- `bus_wait_i` in 1: asynchronous, active-high strobe extension.

## Operation
- A request is accepted on the edge where `address_valid_i && ready_o`. Address, write flag and write data are latched at that edge.
- A request presented while `ready_o` is low is ignored. There is no queue; the CPU holds its request.
- The FSM runs IDLE → SETUP → STROBE → HOLD → IDLE.
  - IDLE: `ready_o` = 1.
  - SETUP (`SETUP_CYCLES` cycles; skipped if 0): address driven. On writes, data is driven and `bus_data_oe_o` = 1. Both strobes are high.
  - STROBE: `bus_rd_n_o` (read) or `bus_wr_n_o` (write) is low.
    - Exit after `STROBE_CYCLES` cycles if the synchronised wait is low.
    - Otherwise remain, re-checking every cycle.
    - Forced exit when the strobe cycle count reaches `TIMEOUT_CYCLES`.
  - HOLD (`HOLD_CYCLES` cycles): strobes high; address, data and `bus_data_oe_o` unchanged.
- Read data is sampled from `bus_data_i` on the edge leaving STROBE.
  - On a timeout, `data_o` is instead set to all-ones.
- `done_o` pulses in the first HOLD cycle. `data_valid_o` pulses with it on reads, and `error_o` pulses with it on timeout.
- `bus_wait_i` passes through a 2-flop synchroniser. To extend the strobe, the device must assert wait no later than strobe cycle `STROBE_CYCLES-2`.
- Only one strobe is ever low at a time. The strobes are never low outside STROBE.
- The phase counter is sized by `$clog2` of the largest cycle-count parameter plus 1. Its count saturates and does not wrap.

## Timing
- Reset values: `ready_o` 1; `bus_rd_n_o` and `bus_wr_n_o` 1; `bus_data_oe_o` 0; `bus_addr_o`, `bus_data_o` and `data_o` all zero; `done_o`, `data_valid_o` and `error_o` 0; FSM in IDLE.
- Cycle numbering: the accept edge is cycle 0.
  - SETUP occupies cycles 1..S.
  - STROBE occupies cycles S+1..S+T' (T' = actual strobe length).
  - HOLD occupies the next H cycles; `done_o` is in the first of them.
  - `ready_o` rises at cycle S+T'+H+1.
- With defaults and no wait:
  - `ready_o` falls at cycle 1.
  - Strobe is low in cycles 2–3.
  - `done_o` pulses in cycle 4.
  - `ready_o` = 1 in cycle 5.
  - Back-to-back accesses are therefore 5 cycles apart.
- Reset mid-operation: on the first edge with `reset_i` = 0, all outputs take their reset values and the FSM returns to IDLE. No `done_o` is issued for the aborted access.
- Parameter violations (`STROBE_CYCLES` < 1, `HOLD_CYCLES` < 1, `TIMEOUT_CYCLES` < `STROBE_CYCLES`) cause an elaboration-time `$error`.

## Structure
- Shared package `ext_bus_pkg`: `ext_bus_state_t` enum (IDLE, SETUP, STROBE, HOLD) and a `max3` function for counter sizing.
- Sub-module `sync2`: 2-flop synchroniser with reset value 0, used for `bus_wait_i`. It is reusable for other GPIO inputs.

## Test plan
- Read with defaults: address 0x8000, device drives `bus_data_i` = 0x5A. Expect `bus_rd_n_o` low in cycles 2–3, then `data_o` = 0x5A with `data_valid_o` and `done_o` in cycle 4, and `ready_o` in cycle 5.
- Write 0x3C to 0x2007: `bus_data_oe_o` = 1 in cycles 1–4, `bus_wr_n_o` low in cycles 2–3, `bus_data_o` = 0x3C, `done_o` at cycle 4, no `data_valid_o`.
- Wait stretch: `bus_wait_i` high from cycle 1 to cycle 6. Strobe stays low until two cycles after wait drops (synchroniser latency), and `error_o` stays 0.
- Timeout with `TIMEOUT_CYCLES` = 8 and wait stuck high: strobe is low for exactly 8 cycles, then `done_o`, `error_o` and `data_valid_o` pulse together with `data_o` = 0xFF.
- `SETUP_CYCLES` = 0, `HOLD_CYCLES` = 3: strobe falls in cycle 1, `ready_o` returns at cycle 6. A request held during busy is accepted at cycle 6, not earlier.
- Reset asserted during STROBE: strobes high and `ready_o` = 1 after the next edge, with no `done_o`. A following read completes normally.
